// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and control-level constants.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_REQ  = 2'd1,
      IF_DROP = 2'd2
   } if_state_e;

   localparam logic STOP         = 1'b1;
   localparam logic NO_STOP      = 1'b0;
   localparam logic BRANCH       = 1'b1;
   localparam logic NOT_BRANCH   = 1'b0;
   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Prefetch buffer: synchronous FIFO with flush. Flush wins over push/pop in the same cycle;
// the head word is forced to zero while the buffer is empty.
module if_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [WIDTH-1:0]             i_data,
   output logic [WIDTH-1:0]             o_data,
   output logic                         o_valid,
   output logic [$clog2(DEPTH):0]       o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic w_full;
   logic w_empty;
   logic w_do_pop;
   logic w_do_push;

   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !i_flush && !w_empty;
   assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked until a word has been written.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_valid = !w_empty;
   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC generator, single-outstanding req/ack memory fetch FSM and prefetch buffer.
// Optional performance counters are built when IF_FETCH_PERF_EN is defined.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                INST_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 4,
   parameter int                STALL_W    = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [STALL_W-1:0]  stall,
   input  logic                branch_flag_i,
   input  logic [ADDR_W-1:0]   branch_address_i,
   output logic                mem_req_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   input  logic                mem_ack_i,
   input  logic [INST_W-1:0]   mem_data_i,
   output logic                if_valid_o,
   output logic [ADDR_W-1:0]   if_pc_o,
   output logic [INST_W-1:0]   if_inst_o,
`ifdef IF_FETCH_PERF_EN
   output logic [31:0]         perf_fetch_cnt_o,
   output logic [31:0]         perf_flush_cnt_o,
`endif
   output logic [1:0]          o_dbg_state
);

   localparam int                STEP       = INST_W / 8;
   localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int                ENTRY_W    = ADDR_W + INST_W;
   localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(STEP);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));
   localparam logic [CNT_W-1:0]  FIFO_FULL  = CNT_W'(FIFO_DEPTH);

   if_state_e         r_state;
   if_state_e         w_state_nxt;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] w_fetch_pc_nxt;
   logic              r_mem_req;
   logic              w_mem_req_nxt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [ADDR_W-1:0] w_mem_addr_nxt;

   logic              w_branch;
   logic              w_fetch_stop;
   logic              w_dec_hold;
   logic [ADDR_W-1:0] w_target;
   logic              w_push;
   logic              w_pop;
   logic [ENTRY_W-1:0] w_head;
   logic              w_head_valid;
   logic [CNT_W-1:0]  w_fifo_count;
   logic [CNT_W-1:0]  w_post_cnt;
   logic              w_room;
   logic              w_room_after;
   logic              w_unused_stall;

   assign w_branch     = (branch_flag_i == BRANCH);
   assign w_fetch_stop = (stall[0] == STOP);
   assign w_dec_hold   = (stall[1] == STOP);
   assign w_target     = branch_address_i & ALIGN_MASK;
   assign w_unused_stall = ^stall;

   // A redirect flushes the buffer, so the pop of that cycle is suppressed too.
   assign w_pop        = w_head_valid && !w_dec_hold && !w_branch;
   assign w_post_cnt   = w_fifo_count + CNT_W'(1) - CNT_W'(w_pop);
   assign w_room       = (w_fifo_count < FIFO_FULL);
   assign w_room_after = (w_post_cnt < FIFO_FULL);

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_mem_req_nxt  = r_mem_req;
      w_mem_addr_nxt = r_mem_addr;
      w_push         = 1'b0;
      case (r_state)
         IF_IDLE: begin
            if (w_branch) begin
               w_fetch_pc_nxt = w_target;
            end else if (!w_fetch_stop && w_room) begin
               w_state_nxt    = IF_REQ;
               w_mem_req_nxt  = CHIP_ENABLE;
               w_mem_addr_nxt = r_fetch_pc;
            end
         end
         IF_REQ: begin
            if (w_branch) begin
               w_fetch_pc_nxt = w_target;
               if (mem_ack_i) begin
                  w_state_nxt   = IF_IDLE;
                  w_mem_req_nxt = CHIP_DISABLE;
               end else begin
                  w_state_nxt = IF_DROP;
               end
            end else if (mem_ack_i) begin
               w_push         = 1'b1;
               w_fetch_pc_nxt = r_fetch_pc + STEP_A;
               if (w_room_after && !w_fetch_stop) begin
                  w_mem_addr_nxt = r_fetch_pc + STEP_A;
               end else begin
                  w_state_nxt   = IF_IDLE;
                  w_mem_req_nxt = CHIP_DISABLE;
               end
            end
         end
         IF_DROP: begin
            // The old request stays on the bus until the memory answers it.
            if (w_branch) w_fetch_pc_nxt = w_target;
            if (mem_ack_i) begin
               w_state_nxt   = IF_IDLE;
               w_mem_req_nxt = CHIP_DISABLE;
            end
         end
         default: begin
            w_state_nxt   = IF_IDLE;
            w_mem_req_nxt = CHIP_DISABLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IF_IDLE;
         r_fetch_pc <= RESET_PC;
         r_mem_req  <= CHIP_DISABLE;
         r_mem_addr <= RESET_PC;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_mem_req  <= w_mem_req_nxt;
         r_mem_addr <= w_mem_addr_nxt;
      end
   end

   if_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_branch),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  ({r_fetch_pc, mem_data_i}),
      .o_data  (w_head),
      .o_valid (w_head_valid),
      .o_count (w_fifo_count)
   );

   assign mem_req_o   = r_mem_req;
   assign mem_addr_o  = r_mem_addr;
   assign if_valid_o  = w_head_valid;
   assign if_pc_o     = w_head[ENTRY_W-1 -: ADDR_W];
   assign if_inst_o   = w_head[INST_W-1:0];
   assign o_dbg_state = r_state;

`ifdef IF_FETCH_PERF_EN
   logic [31:0] r_perf_fetch_cnt;
   logic [31:0] r_perf_flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_fetch_cnt <= '0;
         r_perf_flush_cnt <= '0;
      end else begin
         if (w_push)   r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
         if (w_branch) r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
   end

   assign perf_fetch_cnt_o = r_perf_fetch_cnt;
   assign perf_flush_cnt_o = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic, checked against a
// request-level model (expected fetch address, expected request line, expected {pc,inst} queue).
module tb_if_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic        branch_flag_i = 1'b0;
   logic [31:0] branch_address_i = '0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_data_i = '0;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic [1:0]  dbg_state;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt_o;
   logic [31:0] perf_flush_cnt_o;
`endif

   if_fetch_unit dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .branch_flag_i    (branch_flag_i),
      .branch_address_i (branch_address_i),
      .mem_req_o        (mem_req_o),
      .mem_addr_o       (mem_addr_o),
      .mem_ack_i        (mem_ack_i),
      .mem_data_i       (mem_data_i),
      .if_valid_o       (if_valid_o),
      .if_pc_o          (if_pc_o),
      .if_inst_o        (if_inst_o),
`ifdef IF_FETCH_PERF_EN
      .perf_fetch_cnt_o (perf_fetch_cnt_o),
      .perf_flush_cnt_o (perf_flush_cnt_o),
`endif
      .o_dbg_state      (dbg_state)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [63:0] exp_q[$];
   logic [31:0] req_log[$];
   logic [31:0] next_req_addr = 32'h0;
   logic [31:0] cur_addr = 32'h0;
   bit          req_active = 1'b0;
   bit          cur_dropped = 1'b0;
   bit          exp_req = 1'b0;
   int          wait_cnt = 0;
   int          lat = 0;
   int          fixed_lat = 2;
   bit          rand_lat = 1'b0;
   int unsigned fetch_evt = 0;
   int unsigned flush_evt = 0;
   int          n_vec = 0;
   int          n_err = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs, drive inputs (incl. memory responder), advance model.
   task automatic step_cycle(input logic [5:0] st, input bit br, input logic [31:0] tgt);
      int sz_before;
      bit ack;
      bit was_active;
      chk("mem_req", mem_req_o, exp_req);
      chk("if_valid", if_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("if_head", {if_pc_o, if_inst_o}, exp_q[0]);
      if (mem_req_o && !req_active) begin
         chk("req_addr", mem_addr_o, next_req_addr);
         req_active  = 1'b1;
         cur_addr    = mem_addr_o;
         cur_dropped = 1'b0;
         wait_cnt    = 0;
         lat         = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
         req_log.push_back(mem_addr_o);
      end else if (req_active) begin
         chk("req_addr_hold", mem_addr_o, cur_addr);
      end
      ack = req_active && (wait_cnt == lat);
      if (!ack) wait_cnt++;
      mem_ack_i        = ack;
      mem_data_i       = ack ? mem_word(cur_addr) : $urandom();
      stall            = st;
      branch_flag_i    = br;
      branch_address_i = br ? tgt : $urandom();
      sz_before  = exp_q.size();
      was_active = req_active;
      if (br) begin
         exp_q.delete();
         next_req_addr = tgt & ~32'd3;
         flush_evt++;
         if (req_active) cur_dropped = 1'b1;
      end else if (sz_before != 0 && !st[1]) begin
         void'(exp_q.pop_front());
      end
      if (ack) begin
         if (!cur_dropped) begin
            exp_q.push_back({cur_addr, mem_word(cur_addr)});
            next_req_addr = cur_addr + 32'd4;
            fetch_evt++;
         end
         req_active = 1'b0;
      end
      if (was_active && !ack)
         exp_req = 1'b1;
      else if (ack)
         exp_req = !cur_dropped && !st[0] && (exp_q.size() < DEPTH);
      else
         exp_req = !br && !st[0] && (sz_before < DEPTH);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          found;
      int unsigned base;
      logic [5:0]  st;
      logic [31:0] tgt;
      logic [31:0] got;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", mem_req_o, 1'b0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_if_valid", if_valid_o, 1'b0);
      chk("rst_if_pc", if_pc_o, 32'h0);
      chk("rst_if_inst", if_inst_o, 32'h0);
`ifdef IF_FETCH_PERF_EN
      chk("rst_perf_fetch", perf_fetch_cnt_o, 32'h0);
      chk("rst_perf_flush", perf_flush_cnt_o, 32'h0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // 1: sequential fetch from reset, ack two cycles after each request
      fixed_lat = 2;
      repeat (16) step_cycle(6'b000000, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         got = (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
         chk("t1_addr", got, 32'(i * 4));
      end

      // 2: decode stall fills buffer with exactly DEPTH words, then release
      fixed_lat = 1;
      step_cycle(6'b000010, 1'b1, 32'h40);
      base = fetch_evt;
      repeat (30) step_cycle(6'b000010, 1'b0, 32'h0);
      chk("t2_acks", fetch_evt - base, DEPTH);
      chk("t2_req_idle", mem_req_o, 1'b0);
      chk("t2_full_valid", if_valid_o, 1'b1);
      repeat (20) step_cycle(6'b000000, 1'b0, 32'h0);

      // 3: redirect while request at 0x8 is outstanding
      fixed_lat = 3;
      step_cycle(6'b000000, 1'b1, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (mem_req_o && mem_addr_o == 32'h8 && !(req_active && wait_cnt == fixed_lat)) found = 1'b1;
         else step_cycle(6'b000000, 1'b0, 32'h0);
      end
      chk("t3_reach", found, 1'b1);
      step_cycle(6'b000000, 1'b1, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (if_valid_o) found = 1'b1;
         else step_cycle(6'b000000, 1'b0, 32'h0);
      end
      chk("t3_valid_seen", found, 1'b1);
      chk("t3_first_pc", if_pc_o, 32'h100);
      repeat (6) step_cycle(6'b000000, 1'b0, 32'h0);

      // 4: redirect in the same cycle as an ack and a pop
      fixed_lat = 2;
      step_cycle(6'b000010, 1'b1, 32'h80);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (req_active && wait_cnt == fixed_lat && if_valid_o) found = 1'b1;
         else step_cycle(6'b000010, 1'b0, 32'h0);
      end
      chk("t4_reach", found, 1'b1);
      step_cycle(6'b000000, 1'b1, 32'h300);
      chk("t4_flushed", if_valid_o, 1'b0);
      repeat (10) step_cycle(6'b000000, 1'b0, 32'h0);

      // 5: fetch stall during a request, redirect under stall to an unaligned target
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (mem_req_o && !req_active) found = 1'b1;
         else step_cycle(6'b000000, 1'b0, 32'h0);
      end
      chk("t5_reach", found, 1'b1);
      repeat (8) step_cycle(6'b000001, 1'b0, 32'h0);
      chk("t5_no_req", mem_req_o, 1'b0);
      step_cycle(6'b000001, 1'b1, 32'h203);
      repeat (3) step_cycle(6'b000001, 1'b0, 32'h0);
      chk("t5_still_idle", mem_req_o, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (mem_req_o) found = 1'b1;
         else step_cycle(6'b000000, 1'b0, 32'h0);
      end
      chk("t5_req_seen", found, 1'b1);
      chk("t5_req_addr", mem_addr_o, 32'h200);
      repeat (8) step_cycle(6'b000000, 1'b0, 32'h0);

      // 6: PC wrap at the top of the address space
      fixed_lat = 1;
      step_cycle(6'b000000, 1'b1, 32'hFFFF_FFFC);
      req_log.delete();
      repeat (12) step_cycle(6'b000000, 1'b0, 32'h0);
      got = (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF;
      chk("t6_addr_top", got, 32'hFFFF_FFFC);
      got = (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF;
      chk("t6_addr_wrap", got, 32'h0);

      // Randomized traffic: stalls, redirects (some near the wrap point), random latencies
      rand_lat = 1'b1;
      for (int i = 0; i < 400; i++) begin
         st = {4'($urandom()), ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 20)};
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
         step_cycle(st, ($urandom_range(0, 99) < 5), tgt);
      end
      repeat (20) step_cycle(6'b000000, 1'b0, 32'h0);

`ifdef IF_FETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt_o, fetch_evt);
      chk("perf_flush", perf_flush_cnt_o, flush_evt);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
